// File: rtl/sb_pkg.sv
// Shared constants and types for the GPR write scoreboard.
package sb_pkg;
    localparam int NUM_REGS  = 32;
    localparam int CNT_W     = 2;
    localparam int REG_IDX_W = 5;
    localparam int FLUSH_WIN = 4;

    typedef logic [CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one GPR: +1 on issue, -1 on retire, cleared by flush.
module sb_counter #(
    parameter int CNT_W = sb_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             sat,
    output logic             underflow
);
    logic [CNT_W-1:0] r_cnt;

    assign cnt       = r_cnt;
    assign zero      = (r_cnt == '0);
    assign sat       = (r_cnt == '1);
    // A retire paired with a same-cycle issue is a net no-op, never an underflow.
    assign underflow = dec && !inc && zero;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (inc && !dec && !sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/reg_scoreboard.sv
// GPR dependency scoreboard for ID: per-register pending-write counters drive ds_stall.
// Optional build macro SB_WB_BYPASS_EN: a source whose only pending write is retiring this cycle does not stall.
module reg_scoreboard #(
    parameter int NUM_REGS = sb_pkg::NUM_REGS,
    parameter int CNT_W    = sb_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ds_valid,
    input  logic [4:0] ds_rj,
    input  logic [4:0] ds_rk,
    input  logic [4:0] ds_rd,
    input  logic       ds_rj_use,
    input  logic       ds_rk_use,
    input  logic       ds_rd_use,
    input  logic       ds_gr_we,
    input  logic [4:0] ds_dest,
    input  logic       ds_fire,
    input  logic       ws_we,
    input  logic [4:0] ws_dest,
    input  logic       flush,
    output logic       ds_stall,
    output logic [6:0] sb_inflight,
    output logic       sb_err
);
    import sb_pkg::*;

    localparam int WIN_W = $clog2(FLUSH_WIN + 1);

    logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
    logic [NUM_REGS-1:0]            w_zero;
    logic [NUM_REGS-1:0]            w_sat;
    logic [NUM_REGS-1:0]            w_uf;

    logic       w_issue, w_retire, w_retire_cnt, w_quiet;
    logic       w_haz_rj, w_haz_rk, w_haz_rd, w_haz_sat;
    logic       w_byp_rj, w_byp_rk, w_byp_rd;
    logic [6:0] r_inflight;
    logic       r_err;
    logic [WIN_W-1:0] r_win;

    // r0 is hard-wired: never pending, never saturated, never underflows.
    assign w_cnt[0]  = '0;
    assign w_zero[0] = 1'b1;
    assign w_sat[0]  = 1'b0;
    assign w_uf[0]   = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (w_issue && (ds_dest == REG_IDX_W'(i))),
            .dec       (w_retire && (ws_dest == REG_IDX_W'(i))),
            .clr       (flush),
            .cnt       (w_cnt[i]),
            .zero      (w_zero[i]),
            .sat       (w_sat[i]),
            .underflow (w_uf[i])
        );
    end

`ifdef SB_WB_BYPASS_EN
    assign w_byp_rj = ws_we && (ws_dest == ds_rj) && (w_cnt[ds_rj] == CNT_W'(1));
    assign w_byp_rk = ws_we && (ws_dest == ds_rk) && (w_cnt[ds_rk] == CNT_W'(1));
    assign w_byp_rd = ws_we && (ws_dest == ds_rd) && (w_cnt[ds_rd] == CNT_W'(1));
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^w_cnt;
    assign w_byp_rj = 1'b0;
    assign w_byp_rk = 1'b0;
    assign w_byp_rd = 1'b0;
`endif

    assign w_haz_rj  = ds_valid && ds_rj_use && (ds_rj != '0) && !w_zero[ds_rj] && !w_byp_rj;
    assign w_haz_rk  = ds_valid && ds_rk_use && (ds_rk != '0) && !w_zero[ds_rk] && !w_byp_rk;
    assign w_haz_rd  = ds_valid && ds_rd_use && (ds_rd != '0) && !w_zero[ds_rd] && !w_byp_rd;
    assign w_haz_sat = ds_valid && ds_gr_we && (ds_dest != '0) && w_sat[ds_dest];
    assign ds_stall  = w_haz_rj || w_haz_rk || w_haz_rd || w_haz_sat;

    // A fire that arrives while stalled is discarded rather than trusted.
    assign w_issue      = ds_fire && !ds_stall && ds_gr_we && (ds_dest != '0);
    assign w_retire     = ws_we && (ws_dest != '0);
    assign w_retire_cnt = w_retire && !w_uf[ws_dest];
    assign w_quiet      = flush || (r_win != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
            r_win      <= '0;
        end else if (flush) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
            r_win      <= WIN_W'(FLUSH_WIN);
        end else begin
            r_inflight <= r_inflight + {6'b0, w_issue} - {6'b0, w_retire_cnt};
            if ((|w_uf) && !w_quiet) begin
                r_err <= 1'b1;
            end
            if (r_win != '0) begin
                r_win <= r_win - WIN_W'(1);
            end
        end
    end

    assign sb_inflight = r_inflight;
    assign sb_err      = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: vector table, directed flush/reset sequences, random vs. model.
module tb_reg_scoreboard;
    import sb_pkg::*;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXC = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset, ds_valid, ds_rj_use, ds_rk_use, ds_rd_use, ds_gr_we, ds_fire;
    logic       ws_we, flush;
    logic [4:0] ds_rj, ds_rk, ds_rd, ds_dest, ws_dest;
    logic       ds_stall, sb_err;
    logic [6:0] sb_inflight;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending writes per register, and cycles since the last flush.
    int mcnt [32];
    int minfl;
    bit merr;
    int after_fl;

    reg_scoreboard dut (
        .clk(clk), .reset(reset), .ds_valid(ds_valid),
        .ds_rj(ds_rj), .ds_rk(ds_rk), .ds_rd(ds_rd),
        .ds_rj_use(ds_rj_use), .ds_rk_use(ds_rk_use), .ds_rd_use(ds_rd_use),
        .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_fire(ds_fire),
        .ws_we(ws_we), .ws_dest(ws_dest), .flush(flush),
        .ds_stall(ds_stall), .sb_inflight(sb_inflight), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rj;
        logic       rj_use;
        logic [4:0] rk;
        logic       rk_use;
        logic       gr_we;
        logic [4:0] dest;
        logic       fire;
        logic       we;
        logic [4:0] wdest;
        logic       exp_stall;
        int         exp_infl;
        logic       exp_err;
    } vec_t;

    vec_t tv [19];

    function automatic vec_t mk(input logic v, input int rj, input logic ru, input int rk, input logic ku,
                                input logic gw, input int d, input logic f, input logic w, input int wd,
                                input logic es, input int ei, input logic ee);
        vec_t t;
        t.valid = v;   t.rj = 5'(rj);  t.rj_use = ru; t.rk = 5'(rk); t.rk_use = ku;
        t.gr_we = gw;  t.dest = 5'(d); t.fire = f;    t.we = w;      t.wdest = 5'(wd);
        t.exp_stall = es; t.exp_infl = ei; t.exp_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_in();
        ds_valid = 0; ds_rj = 0; ds_rk = 0; ds_rd = 0;
        ds_rj_use = 0; ds_rk_use = 0; ds_rd_use = 0;
        ds_gr_we = 0; ds_dest = 0; ds_fire = 0;
        ws_we = 0; ws_dest = 0; flush = 0;
    endtask

    // Inputs are applied 1 time unit after the edge; outputs are checked mid-cycle.
    task automatic sample(input string tag, input logic es, input int ei, input logic ee);
        #4;
        chk({tag, "_stall"}, {31'b0, ds_stall}, {31'b0, es});
        chk({tag, "_inflight"}, {25'b0, sb_inflight}, ei);
        chk({tag, "_err"}, {31'b0, sb_err}, {31'b0, ee});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit src_haz(input logic use_f, input logic [4:0] r);
        if (!ds_valid || !use_f || r == 0 || mcnt[r] == 0) return 1'b0;
        if (BYP && mcnt[r] == 1 && ws_we && ws_dest == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit mstall();
        bit s;
        s = src_haz(ds_rj_use, ds_rj) || src_haz(ds_rk_use, ds_rk) || src_haz(ds_rd_use, ds_rd);
        if (ds_valid && ds_gr_we && ds_dest != 0 && mcnt[ds_dest] == MAXC) s = 1'b1;
        return s;
    endfunction

    task automatic model_step(input bit stall_now);
        bit issue, retire, quiet;
        if (reset || flush) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            minfl = 0;
            merr = 1'b0;
            after_fl = reset ? 100 : 1;
        end else begin
            quiet  = (after_fl >= 1 && after_fl <= FLUSH_WIN);
            issue  = ds_fire && !stall_now && ds_gr_we && ds_dest != 0;
            retire = ws_we && ws_dest != 0;
            if (!(issue && retire && ds_dest == ws_dest)) begin
                if (issue) begin
                    mcnt[ds_dest]++;
                    minfl++;
                end
                if (retire) begin
                    if (mcnt[ws_dest] > 0) begin
                        mcnt[ws_dest]--;
                        minfl--;
                    end else if (!quiet) begin
                        merr = 1'b1;
                    end
                end
            end
            if (after_fl < 100) after_fl++;
        end
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ds_valid = 1; ds_rj = 5; ds_rj_use = 1;
        sample("reset_state", 0, 0, 0);
        clr_in();

        tv[0]  = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 1, 1, 0);
        tv[2]  = mk(1, 5, 1, 0, 0, 1, 6, 0, 1, 5, !BYP, 1, 0);
        tv[3]  = mk(1, 5, 1, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0);
        tv[4]  = mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        tv[5]  = mk(1, 0, 0, 6, 1, 0, 0, 0, 1, 6, !BYP, 1, 0);
        tv[6]  = mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[7]  = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0);
        tv[8]  = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 1, 0);
        tv[9]  = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 2, 0);
        tv[10] = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 1, 3, 0);
        tv[11] = mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 1, 3, 0);
        tv[12] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 2, 0);
        tv[13] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 2, 0);
        tv[14] = mk(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0, 3, 0);
        tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        tv[16] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        tv[17] = mk(1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 3, 0);
        tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

        for (int i = 0; i < 19; i++) begin
            ds_valid = tv[i].valid; ds_rj = tv[i].rj; ds_rj_use = tv[i].rj_use;
            ds_rk = tv[i].rk; ds_rk_use = tv[i].rk_use; ds_gr_we = tv[i].gr_we;
            ds_dest = tv[i].dest; ds_fire = tv[i].fire; ws_we = tv[i].we; ws_dest = tv[i].wdest;
            sample($sformatf("vec%0d", i), tv[i].exp_stall, tv[i].exp_infl, tv[i].exp_err);
            tick();
        end
        clr_in();

        // Build inflight=5 with two r3 writers, then reset mid-flight.
        ds_valid = 1; ds_gr_we = 1; ds_dest = 3; ds_fire = 1;
        sample("r3_a", 0, 3, 0);
        tick();
        sample("r3_b", 0, 4, 0);
        tick();
        clr_in();
        reset = 1; ds_valid = 1; ds_rj = 3; ds_rj_use = 1;
        sample("rst_pre", 1, 5, 0);
        tick();
        reset = 0;
        sample("rst_post", 0, 0, 0);
        tick();

        // Flush with cnt[3]=2; drained WBs inside the window are silent, later ones flag.
        clr_in();
        ds_valid = 1; ds_gr_we = 1; ds_dest = 3; ds_fire = 1;
        sample("fl_iss_a", 0, 0, 0);
        tick();
        sample("fl_iss_b", 0, 1, 0);
        tick();
        clr_in();
        ds_valid = 1; ds_rk = 3; ds_rk_use = 1; flush = 1;
        sample("fl_cyc", 1, 2, 0);
        tick();
        flush = 0; ws_we = 1; ws_dest = 3;
        sample("fl_p1", 0, 0, 0);
        tick();
        sample("fl_p2", 0, 0, 0);
        tick();
        ws_we = 0;
        sample("fl_p3", 0, 0, 0);
        tick();
        ws_we = 1;
        sample("fl_p4", 0, 0, 0);
        tick();
        ws_we = 0;
        sample("fl_p5", 0, 0, 0);
        tick();
        ws_we = 1;
        sample("fl_p6", 0, 0, 0);
        tick();
        ws_we = 0;
        sample("fl_p7", 0, 0, 1);
        tick();
        sample("fl_p8", 0, 0, 1);
        tick();
        flush = 1;
        sample("fl_again", 0, 0, 1);
        tick();
        flush = 0;
        sample("fl_clr", 0, 0, 0);
        tick();

        // Random traffic against the reference model.
        clr_in();
        reset = 1;
        tick();
        reset = 0;
        foreach (mcnt[i]) mcnt[i] = 0;
        minfl = 0;
        merr = 1'b0;
        after_fl = 100;
        for (int n = 0; n < 3000; n++) begin
            bit es;
            ds_valid  = ($urandom_range(0, 3) != 0);
            ds_rj     = 5'($urandom_range(0, 7));
            ds_rk     = 5'($urandom_range(0, 7));
            ds_rd     = 5'($urandom_range(0, 7));
            ds_rj_use = 1'($urandom_range(0, 1));
            ds_rk_use = 1'($urandom_range(0, 1));
            ds_rd_use = 1'($urandom_range(0, 1));
            ds_gr_we  = ($urandom_range(0, 3) != 0);
            ds_dest   = 5'($urandom_range(0, 7));
            ds_fire   = 1'($urandom_range(0, 1));
            ws_we     = ($urandom_range(0, 2) == 0);
            ws_dest   = 5'($urandom_range(0, 7));
            if (mcnt[ws_dest] == 0 && $urandom_range(0, 7) != 0) begin
                for (int k = 1; k < 8; k++) begin
                    if (mcnt[k] != 0) ws_dest = 5'(k);
                end
            end
            flush = ($urandom_range(0, 79) == 0);
            reset = ($urandom_range(0, 399) == 0);
            es = mstall();
            sample("rnd", es, minfl, merr);
            model_step(es);
            tick();
        end
        clr_in();
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-dependency scoreboard between ID and the rest of the five-stage LoongArch pipeline. It keeps a pending-write counter for each of the 32 GPRs. Counters increment when an instruction leaves ID toward EX and decrement when WB writes the register file. ID consults the block every cycle: `ds_stall` holds the instruction in ID while any source register it reads still has an older write in flight. The scoreboard replaces the three-way destination compare against EX/MS/WS.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural GPRs; r0 is never tracked.
- CNT_W, 2, counter width; at most 2^CNT_W-1 writes in flight per register.

Ports (name, direction, width, meaning):
- clk  in  1  pipeline clock; the only clock in the block.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- ds_valid  in  1  ID holds a valid instruction.
- ds_rj / ds_rk / ds_rd  in  5 each  source register fields.
- ds_rj_use / ds_rk_use / ds_rd_use  in  1 each  the corresponding field is a real source operand.
- ds_gr_we  in  1  the instruction writes a GPR.
- ds_dest  in  5  destination register (already r1 for bl).
- ds_fire  in  1  instruction leaves ID this cycle (ds_to_es_valid && es_allowin).
- ws_we  in  1  WB register-file write this cycle (rf_we && ws_valid).
- ws_dest  in  5  WB destination.
- flush  in  1  clears all tracking state; the pipeline is drained beyond ID.
- ds_stall  out  1  combinational; ID must not go ready.
- sb_inflight  out  7  registered total of pending writes across all registers.
- sb_err  out  1  registered, sticky; a WB write arrived for a register whose counter was 0.

## Operation
- A tracked issue is ds_fire && ds_gr_we && ds_dest!=0. It increments cnt[ds_dest].
- A tracked retire is ws_we && ws_dest!=0. It decrements cnt[ws_dest].
- Issue and retire to the same register in the same cycle leave the counter unchanged. Issue and retire to different registers update both counters.
- Retire on a zero counter: the counter stays 0 and sb_err is set, except in the cycle of a flush and the 4 cycles after it. During that window, writebacks from drained instructions are expected and ignored silently.
- Each source hazard is valid && use && reg!=0 && cnt[reg]!=0, evaluated for rj, rk and rd.
- ds_stall is asserted when:
  - any source hazard is true, or
  - ds_valid && ds_gr_we && ds_dest!=0 && cnt[ds_dest]==2^CNT_W-1 (saturation guard).
- When ds_stall is high, ds_fire is low by construction of ID. The block ignores any ds_fire asserted while ds_stall is high.
- flush: all counters, sb_inflight and the window counter are set to 0/reloaded on the next edge. flush has priority over issue/retire in the same cycle. sb_err is cleared by flush.
- sb_inflight = sum of counters, maintained incrementally (+1 per issue, -1 per counted retire).

## Timing
- Counters update on the rising edge after the issue/retire cycle. ds_stall reflects the new value in the following cycle.
- ds_stall has zero-cycle latency from the ID inputs.
- Load-use needs no special case: the counter stays nonzero until the load's WB.
- Reset: all counters 0, sb_inflight=0, sb_err=0, flush-window counter 0. ds_stall is 0 whenever ds_valid=0.
- Reset mid-operation discards all state; the pipeline is reset on the same edge.

## Configuration
- SB_WB_BYPASS_EN defined:
  - A source hazard is suppressed when cnt[reg]==1 && ws_we && ws_dest==reg in the same cycle.
  - The register file must write-through (read returns wdata when waddr matches raddr during a write).
- SB_WB_BYPASS_EN undefined:
  - The source waits until the counter reads 0, one cycle after WB.
  - The regfile needs no write-through.

## Structure
- Shared package sb_pkg: NUM_REGS, CNT_W, REG_IDX_W=5, FLUSH_WIN=4, and typedef sb_cnt_t (CNT_W bits).
- Sub-module sb_counter, instantiated 31 times for r1..r31:
  - inputs: inc, dec, clr.
  - outputs: cnt, zero flag, saturated flag, underflow pulse.
- The top level holds only hazard compares, the inflight adder, the error flag and the window counter.

## Test plan
- Issue add.w r5 (ds_fire) then present add.w r6,r5,r0 → ds_stall=1 until the WB of r5. Without bypass, stall drops the cycle after ws_we/ws_dest=5; with SB_WB_BYPASS_EN, it drops in the WB cycle.
- Three back-to-back issues to r7 → cnt[7]=3 and sb_inflight=3. A 4th writer to r7 → ds_stall=1. One WB of r7 → stall drops next cycle.
- Issue r9 and WB r9 in the same cycle with cnt[9]=1 → cnt[9] stays 1 and sb_inflight is unchanged.
- Writers to r0 (e.g. add.w r0 issued and written back) → no counter change, no stall, sb_err=0.
- flush with cnt[3]=2, then WB r3 on cycles +1 and +2 → counters 0, sb_err=0. A WB r3 at cycle +6 → sb_err=1, which stays set until the next flush or reset.
- reset asserted while sb_inflight=5 → next cycle sb_inflight=0, ds_stall=0 for any valid source.
